// File: rtl/multi_flip_flop_pkg.sv
// ----------------------------------------------------------------------------
// multi_flip_flop_pkg
// Shared types and helpers for the configurable multi-mode flip-flop bank.
// The optional sticky SR-illegal flag is compiled in with the macro
// MULTI_FLIP_FLOP_SR_ERR_EN (see multi_flip_flop.sv).
// ----------------------------------------------------------------------------
package multi_flip_flop_pkg;

    // Per-bit behaviour selector; encoding matches the mode input port.
    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_D  = 2'b01,
        MODE_T  = 2'b10,
        MODE_SR = 2'b11
    } mode_t;

    // Width of the mode field, for ports that carry the raw encoding.
    localparam int MODE_W = 2;

    // Convert the raw 2-bit port value into the enum type.
    function automatic mode_t to_mode(input logic [MODE_W-1:0] raw);
        return mode_t'(raw);
    endfunction

    // S and R both asserted in SR mode is the one illegal input combination.
    function automatic logic is_sr_illegal(input mode_t mode,
                                           input logic  s,
                                           input logic  r);
        return (mode == MODE_SR) && s && r;
    endfunction

endpackage : multi_flip_flop_pkg

// File: rtl/ff_next_state_cell.sv
// ----------------------------------------------------------------------------
// ff_next_state_cell
// Purely combinational next-state decode for a single flip-flop bit.
// Inputs a/b are interpreted as J/K, D/-, T/- or S/R depending on mode.
// 'illegal' flags the SR 11 combination; the bit holds in that case.
// ----------------------------------------------------------------------------
module ff_next_state_cell
    import multi_flip_flop_pkg::*;
(
    input  mode_t mode,
    input  logic  a,
    input  logic  b,
    input  logic  q,
    output logic  nxt,
    output logic  illegal
);

    // Decode the next value of this bit from the selected behaviour.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        nxt     = q;
        illegal = 1'b0;
        case (mode)
            MODE_JK: begin
                case ({a, b})
                    2'b00:   nxt = q;
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    default: nxt = ~q;
                endcase
            end
            MODE_D: begin
                nxt = a;
            end
            MODE_T: begin
                nxt = a ? ~q : q;
            end
            MODE_SR: begin
                case ({a, b})
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    default: nxt = q;   // hold, and hold on illegal 11
                endcase
                illegal = is_sr_illegal(mode, a, b);
            end
            default: begin
                nxt = q;
            end
        endcase
    end

endmodule : ff_next_state_cell

// File: rtl/multi_flip_flop.sv
// ----------------------------------------------------------------------------
// multi_flip_flop
// Bank of WIDTH independent flip-flops sharing one mode select, with a
// synchronous active-high clear, an update enable, a registered per-bit
// change indicator and a combinational inverted output.
//
// Optional feature: define MULTI_FLIP_FLOP_SR_ERR_EN to add the err_clr input
// and the sticky sr_err output, which records any enabled SR-mode edge that
// saw S and R asserted together on some bit.
// ----------------------------------------------------------------------------
module multi_flip_flop
    import multi_flip_flop_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] changed
`ifdef MULTI_FLIP_FLOP_SR_ERR_EN
    ,
    input  logic             err_clr,
    output logic             sr_err
`endif
);

    mode_t            w_mode;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_illegal;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_changed;

    // Mode is used on the same edge it is sampled, no pipelining.
    assign w_mode = to_mode(mode);

    // One next-state cell per bit; bits never interact.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ff_next_state_cell u_cell (
            .mode    (w_mode),
            .a       (a[i]),
            .b       (b[i]),
            .q       (r_q[i]),
            .nxt     (w_nxt[i]),
            .illegal (w_illegal[i])
        );
    end

    // State and change-indicator registers; clear beats enable and data.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (clr) begin
            r_q       <= RESET_VALUE;
            r_changed <= '0;
        end else if (en) begin
            r_q       <= w_nxt;
            r_changed <= w_nxt ^ r_q;
        end else begin
            r_q       <= r_q;
            r_changed <= '0;
        end
    end

`ifdef MULTI_FLIP_FLOP_SR_ERR_EN
    logic r_sr_err;

    // Sticky illegal-SR flag: clear first, then set wins over err_clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_sr_err <= 1'b0;
        end else if (en && (|w_illegal)) begin
            r_sr_err <= 1'b1;
        end else if (err_clr) begin
            r_sr_err <= 1'b0;
        end
    end

    assign sr_err = r_sr_err;
`else
    // Without the error flag the illegal decode has no consumer; fold it
    // into a dummy reduction so the intent of ignoring it is explicit.
    logic w_unused_illegal;
    assign w_unused_illegal = ^w_illegal;
`endif

    assign q       = r_q;
    assign q_bar   = ~r_q;
    assign changed = r_changed;

endmodule : multi_flip_flop

// File: tb/tb_multi_flip_flop.sv
// ----------------------------------------------------------------------------
// tb_multi_flip_flop
// Self-checking bench for multi_flip_flop (WIDTH=8, RESET_VALUE=8'hA5).
// Directed scenarios plus randomized traffic against a characteristic-
// equation reference model. Define MULTI_FLIP_FLOP_SR_ERR_EN to also cover
// the sticky sr_err flag.
// ----------------------------------------------------------------------------
module tb_multi_flip_flop;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic         clk = 1'b0;
    logic         clr;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] q_bar;
    logic [W-1:0] changed;
`ifdef MULTI_FLIP_FLOP_SR_ERR_EN
    logic         err_clr;
    logic         sr_err;
    logic         m_err;
`endif

    // Reference model state
    logic [W-1:0] m_q;
    logic [W-1:0] m_chg;

    int checks = 0;
    int errors = 0;

    multi_flip_flop #(
        .WIDTH       (W),
        .RESET_VALUE (RV)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .en      (en),
        .mode    (mode),
        .a       (a),
        .b       (b),
        .q       (q),
        .q_bar   (q_bar),
        .changed (changed)
`ifdef MULTI_FLIP_FLOP_SR_ERR_EN
        ,
        .err_clr (err_clr),
        .sr_err  (sr_err)
`endif
    );

    always #5 clk = ~clk;

    // Characteristic equations of the four flip-flop types, whole word at once.
    function automatic logic [W-1:0] ref_next(input logic [1:0]   md,
                                              input logic [W-1:0] ja,
                                              input logic [W-1:0] kb,
                                              input logic [W-1:0] qq);
        case (md)
            2'd0:    return (ja & ~qq) | (~kb & qq);           // JK
            2'd1:    return ja;                                // D
            2'd2:    return qq ^ ja;                           // T
            default: return (qq | (ja & ~kb)) & ~(kb & ~ja);   // SR, 11 holds
        endcase
    endfunction

    // One rising edge; the model consumes the same inputs the DUT sampled.
    task automatic advance();
        logic [W-1:0] nq;
        @(posedge clk);
        if (clr) begin
            m_q   = RV;
            m_chg = '0;
`ifdef MULTI_FLIP_FLOP_SR_ERR_EN
            m_err = 1'b0;
`endif
        end else begin
            if (en) begin
                nq    = ref_next(mode, a, b, m_q);
                m_chg = nq ^ m_q;
                m_q   = nq;
            end else begin
                m_chg = '0;
            end
`ifdef MULTI_FLIP_FLOP_SR_ERR_EN
            if (en && mode == 2'd3 && (a & b) != '0) m_err = 1'b1;
            else if (err_clr)                        m_err = 1'b0;
`endif
        end
        #1;
    endtask

    task automatic drive(input logic c, input logic e, input logic [1:0] md,
                         input logic [W-1:0] va, input logic [W-1:0] vb);
        clr  = c;
        en   = e;
        mode = md;
        a    = va;
        b    = vb;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 2'd0, 8'hFF, 8'hFF);
`ifdef MULTI_FLIP_FLOP_SR_ERR_EN
        err_clr = 1'b0;
`endif
        advance();
        checks++;
        if (q !== 8'hA5) begin
            $display("FAIL reset_q: got %h expected %h", q, 8'hA5); errors++;
        end
        checks++;
        if (q_bar !== 8'h5A) begin
            $display("FAIL reset_qbar: got %h expected %h", q_bar, 8'h5A); errors++;
        end
        checks++;
        if (changed !== 8'h00) begin
            $display("FAIL reset_changed: got %h expected %h", changed, 8'h00); errors++;
        end
`ifdef MULTI_FLIP_FLOP_SR_ERR_EN
        checks++;
        if (sr_err !== 1'b0) begin
            $display("FAIL reset_sr_err: got %b expected 0", sr_err); errors++;
        end
`endif
    endtask

    task automatic test_jk();
        drive(1'b0, 1'b1, 2'd0, 8'h0F, 8'hF0);
        advance();
        checks++;
        if (q !== 8'h0F) begin
            $display("FAIL jk_setclr_q: got %h expected %h", q, 8'h0F); errors++;
        end
        checks++;
        if (changed !== 8'hAA) begin
            $display("FAIL jk_setclr_changed: got %h expected %h", changed, 8'hAA); errors++;
        end
        drive(1'b0, 1'b1, 2'd0, 8'hFF, 8'hFF);
        advance();
        checks++;
        if (q !== 8'hF0) begin
            $display("FAIL jk_toggle_q: got %h expected %h", q, 8'hF0); errors++;
        end
        checks++;
        if (changed !== 8'hFF) begin
            $display("FAIL jk_toggle_changed: got %h expected %h", changed, 8'hFF); errors++;
        end
        checks++;
        if (q_bar !== 8'h0F) begin
            $display("FAIL jk_qbar: got %h expected %h", q_bar, 8'h0F); errors++;
        end
    endtask

    task automatic test_d_t_enable();
        drive(1'b0, 1'b1, 2'd1, 8'h3C, 8'h55);
        advance();
        checks++;
        if (q !== 8'h3C) begin
            $display("FAIL d_q: got %h expected %h", q, 8'h3C); errors++;
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 2'd2, 8'h01, 8'h00);
            advance();
            checks++;
            if (q !== 8'h3C) begin
                $display("FAIL t_en0_q[%0d]: got %h expected %h", k, q, 8'h3C); errors++;
            end
            checks++;
            if (changed !== 8'h00) begin
                $display("FAIL t_en0_changed[%0d]: got %h expected %h", k, changed, 8'h00); errors++;
            end
        end
        drive(1'b0, 1'b1, 2'd2, 8'h01, 8'h00);
        advance();
        checks++;
        if (q !== 8'h3D) begin
            $display("FAIL t_q: got %h expected %h", q, 8'h3D); errors++;
        end
        checks++;
        if (changed !== 8'h01) begin
            $display("FAIL t_changed: got %h expected %h", changed, 8'h01); errors++;
        end
    endtask

    task automatic test_sr();
        // Illegal 11 on bit 7 holds q (3D)
        drive(1'b0, 1'b1, 2'd3, 8'h80, 8'h80);
        advance();
        checks++;
        if (q !== 8'h3D) begin
            $display("FAIL sr_illegal_q: got %h expected %h", q, 8'h3D); errors++;
        end
        checks++;
        if (changed !== 8'h00) begin
            $display("FAIL sr_illegal_changed: got %h expected %h", changed, 8'h00); errors++;
        end
`ifdef MULTI_FLIP_FLOP_SR_ERR_EN
        checks++;
        if (sr_err !== 1'b1) begin
            $display("FAIL sr_err_set: got %b expected 1", sr_err); errors++;
        end
        err_clr = 1'b1;
        drive(1'b0, 1'b1, 2'd3, 8'h00, 8'h00);
        advance();
        checks++;
        if (sr_err !== 1'b0) begin
            $display("FAIL sr_err_clear: got %b expected 0", sr_err); errors++;
        end
        drive(1'b0, 1'b1, 2'd3, 8'h80, 8'h80);
        advance();
        checks++;
        if (sr_err !== 1'b1) begin
            $display("FAIL sr_err_set_wins: got %b expected 1", sr_err); errors++;
        end
        err_clr = 1'b0;
`endif
        // Set bit 1, clear bit 0: 3D -> 3E
        drive(1'b0, 1'b1, 2'd3, 8'h02, 8'h01);
        advance();
        checks++;
        if (q !== 8'h3E) begin
            $display("FAIL sr_setclr_q: got %h expected %h", q, 8'h3E); errors++;
        end
        checks++;
        if (changed !== 8'h03) begin
            $display("FAIL sr_setclr_changed: got %h expected %h", changed, 8'h03); errors++;
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 2'd2, 8'hFF, 8'h00);
        advance();
        checks++;
        if (q !== m_q) begin
            $display("FAIL mid_t1_q: got %h expected %h", q, m_q); errors++;
        end
        advance();
        checks++;
        if (q !== m_q) begin
            $display("FAIL mid_t2_q: got %h expected %h", q, m_q); errors++;
        end
        clr = 1'b1;
        advance();
        checks++;
        if (q !== 8'hA5) begin
            $display("FAIL mid_clr_q: got %h expected %h", q, 8'hA5); errors++;
        end
        checks++;
        if (changed !== 8'h00) begin
            $display("FAIL mid_clr_changed: got %h expected %h", changed, 8'h00); errors++;
        end
        clr = 1'b0;
        advance();
        checks++;
        if (q !== 8'h5A) begin
            $display("FAIL mid_after_q: got %h expected %h", q, 8'h5A); errors++;
        end
        checks++;
        if (changed !== 8'hFF) begin
            $display("FAIL mid_after_changed: got %h expected %h", changed, 8'hFF); errors++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 4) != 0),
                  2'($urandom_range(0, 3)),
                  8'($urandom), 8'($urandom));
`ifdef MULTI_FLIP_FLOP_SR_ERR_EN
            err_clr = ($urandom_range(0, 7) == 0);
`endif
            advance();
            checks++;
            if (q !== m_q) begin
                $display("FAIL rand_q[%0d]: got %h expected %h", n, q, m_q); errors++;
            end
            checks++;
            if (q_bar !== ~m_q) begin
                $display("FAIL rand_qbar[%0d]: got %h expected %h", n, q_bar, ~m_q); errors++;
            end
            checks++;
            if (changed !== m_chg) begin
                $display("FAIL rand_changed[%0d]: got %h expected %h", n, changed, m_chg); errors++;
            end
`ifdef MULTI_FLIP_FLOP_SR_ERR_EN
            checks++;
            if (sr_err !== m_err) begin
                $display("FAIL rand_sr_err[%0d]: got %b expected %b", n, sr_err, m_err); errors++;
            end
`endif
        end
        clr = 1'b0;
    endtask

    initial begin
        drive(1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
`ifdef MULTI_FLIP_FLOP_SR_ERR_EN
        err_clr = 1'b0;
        m_err   = 1'b0;
`endif
        m_q   = RV;
        m_chg = '0;
        #2;
        test_reset();
        test_jk();
        test_d_t_enable();
        test_sr();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_multi_flip_flop
